// File: rtl/if_prefetch_stage.sv
// ----------------------------------------------------------------------------
// if_prefetch_stage
// Instruction-fetch stage. Keeps the fetch PC, issues one request at a time to
// a variable-latency instruction memory, and buffers returned words in a small
// circular prefetch queue that the decode stage drains.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-low reset
//   hazard            decode stall: head entry is held, not consumed
//   branch_taken      one-cycle redirect pulse from EXE
//   branch_addr       redirect target
//   imem_req_valid    fetch request valid          (out)
//   imem_req_ready    memory accepts request       (in)
//   imem_addr         fetch address = fetch_pc     (out)
//   imem_rsp_valid    returned word valid          (in)
//   imem_rsp_data     returned instruction word    (in)
//   instr_valid       queue head valid for decode  (out)
//   pc                head fetch address + 4       (out)
//   instruction       head instruction word        (out)
// ----------------------------------------------------------------------------
module if_prefetch_stage #(
    parameter int                     ADDRESS_LEN = 32,
    parameter int                     DEPTH       = 2,
    parameter logic [ADDRESS_LEN-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hazard,
    input  logic                   branch_taken,
    input  logic [ADDRESS_LEN-1:0] branch_addr,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [ADDRESS_LEN-1:0] imem_addr,
    input  logic                   imem_rsp_valid,
    input  logic [ADDRESS_LEN-1:0] imem_rsp_data,
    output logic                   instr_valid,
    output logic [ADDRESS_LEN-1:0] pc,
    output logic [ADDRESS_LEN-1:0] instruction
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0]            DEPTH_W = (CW+1)'(DEPTH);
    localparam logic [ADDRESS_LEN-1:0] WORD    = ADDRESS_LEN'(4);

    logic [ADDRESS_LEN-1:0] fetch_pc;
    logic [ADDRESS_LEN-1:0] req_addr_q;
    logic                   outstanding;
    logic                   drop;

    logic [ADDRESS_LEN-1:0] q_pc   [DEPTH];
    logic [ADDRESS_LEN-1:0] q_data [DEPTH];
    logic [PW-1:0]          rd_ptr;
    logic [PW-1:0]          wr_ptr;
    logic [CW-1:0]          count;

    logic [CW:0] occupancy;
    logic        req_fire;
    logic        push;
    logic        pop;

    // Queue slots already reserved: stored words plus the one in flight.
    // A request is only issued when its word is guaranteed a slot.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, outstanding};

    // A pending drop also blocks requests: after a reset mid-request the old
    // word is still in flight with outstanding already cleared, and a new
    // request must not overlap it.
    assign imem_req_valid = ~outstanding & ~drop & (occupancy < DEPTH_W)
                          & ~branch_taken & rst;
    assign imem_addr      = fetch_pc;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign push = imem_rsp_valid & ~drop & ~branch_taken;
    assign pop  = instr_valid & ~hazard & ~branch_taken;

    assign instr_valid = (count != '0);
    assign pc          = instr_valid ? q_pc[rd_ptr]   : '0;
    assign instruction = instr_valid ? q_data[rd_ptr] : '0;

    // Control state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            req_addr_q  <= RESET_PC;
            outstanding <= 1'b0;
            // A word requested before reset may still come back; discard it.
            drop        <= outstanding;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            if (req_fire) begin
                outstanding <= 1'b1;
                req_addr_q  <= fetch_pc;
                fetch_pc    <= fetch_pc + WORD;
            end

            if (imem_rsp_valid) begin
                outstanding <= 1'b0;
                if (drop | branch_taken)
                    drop <= 1'b0;
            end

            if (branch_taken) begin
                // Flush wins over push/pop/hazard. Any word still in flight
                // belongs to the wrong path and must be dropped on arrival.
                fetch_pc <= branch_addr;
                drop     <= (outstanding | drop) & ~imem_rsp_valid;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Queue storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            q_pc[wr_ptr]   <= req_addr_q + WORD;
            q_data[wr_ptr] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_if_prefetch_stage.sv
module tb_if_prefetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        hazard = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] instruction;

    int total = 0;
    int bad   = 0;

    if_prefetch_stage #(.ADDRESS_LEN(32), .DEPTH(2), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .hazard(hazard),
        .branch_taken(branch_taken), .branch_addr(branch_addr),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .instr_valid(instr_valid),
        .pc(pc), .instruction(instruction)
    );

    always #5 clk = ~clk;

    // Memory model: word at address a is a ^ 32'hDEAD_0000. Not reset, so a
    // request accepted before a DUT reset is still answered afterwards.
    int          mem_lat  = 1;
    logic        mem_busy = 1'b0;
    int          mem_cnt  = 0;
    logic [31:0] mem_addr_l = '0;

    always @(posedge clk) begin
        imem_rsp_valid <= 1'b0;
        if (imem_req_valid && imem_req_ready) begin
            if (mem_lat <= 1) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= imem_addr ^ 32'hDEAD_0000;
            end else begin
                mem_busy   <= 1'b1;
                mem_cnt    <= mem_lat - 1;
                mem_addr_l <= imem_addr;
            end
        end else if (mem_busy) begin
            if (mem_cnt == 1) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= mem_addr_l ^ 32'hDEAD_0000;
                mem_busy       <= 1'b0;
            end else begin
                mem_cnt <= mem_cnt - 1;
            end
        end
    end

    // Logs of accepted requests and of words consumed by decode.
    logic [31:0] req_log[$];
    logic [31:0] cons_pc[$];
    logic [31:0] cons_data[$];

    always @(negedge clk) begin
        if (imem_req_valid && imem_req_ready)
            req_log.push_back(imem_addr);
        if (rst && instr_valid && !hazard && !branch_taken) begin
            cons_pc.push_back(pc);
            cons_data.push_back(instruction);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        req_log.delete();
        cons_pc.delete();
        cons_data.delete();
    endtask

    task automatic do_reset();
        imem_req_ready = 1'b0;
        hazard         = 1'b0;
        branch_taken   = 1'b0;
        repeat (6) tick();
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        clear_logs();
    endtask

    task automatic test_reset();
        repeat (2) tick();
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want 0", pc); end
        total++; if (instruction !== 32'h0) begin bad++; $display("FAIL reset_instruction: got %h want 0", instruction); end
        rst = 1'b1;
        tick();
        total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL reset_release_req: got %b want 1", imem_req_valid); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_release_addr: got %h want 0", imem_addr); end
    endtask

    task automatic test_stream();
        do_reset();
        mem_lat = 1;
        imem_req_ready = 1'b1;
        repeat (14) tick();
        total++;
        if (req_log.size() < 3 || cons_pc.size() < 3) begin
            bad++; $display("FAIL stream_len: got req=%0d cons=%0d want >=3", req_log.size(), cons_pc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++; if (req_log[i] !== 32'(i*4)) begin bad++; $display("FAIL stream_req%0d: got %h want %h", i, req_log[i], 32'(i*4)); end
                total++; if (cons_pc[i] !== 32'(i*4+4)) begin bad++; $display("FAIL stream_pc%0d: got %h want %h", i, cons_pc[i], 32'(i*4+4)); end
                total++; if (cons_data[i] !== (32'(i*4) ^ 32'hDEAD_0000)) begin bad++; $display("FAIL stream_data%0d: got %h want %h", i, cons_data[i], 32'(i*4) ^ 32'hDEAD_0000); end
            end
        end
    endtask

    task automatic test_hazard();
        int n;
        do_reset();
        mem_lat = 1;
        imem_req_ready = 1'b1;
        n = 0;
        while (!instr_valid && n < 20) begin tick(); n++; end
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL hazard_first_word: got %b want 1 (timeout)", instr_valid); end
        hazard = 1'b1;
        repeat (10) tick();
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL hazard_valid: got %b want 1", instr_valid); end
        total++; if (pc !== 32'h4) begin bad++; $display("FAIL hazard_head_pc: got %h want 4", pc); end
        total++; if (instruction !== 32'hDEAD_0000) begin bad++; $display("FAIL hazard_head_instr: got %h want dead0000", instruction); end
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL hazard_req_stop: got %b want 0", imem_req_valid); end
        total++; if (req_log.size() != 2) begin bad++; $display("FAIL hazard_req_count: got %0d want 2", req_log.size()); end
        total++; if (cons_pc.size() != 0) begin bad++; $display("FAIL hazard_no_consume: got %0d want 0", cons_pc.size()); end
        hazard = 1'b0;
        tick();
        total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL hazard_resume: got %b want 1", imem_req_valid); end
        repeat (20) tick();
        total++;
        if (cons_pc.size() < 4) begin
            bad++; $display("FAIL hazard_stream_len: got %0d want >=4", cons_pc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++; if (cons_pc[i] !== 32'(i*4+4)) begin bad++; $display("FAIL hazard_stream_pc%0d: got %h want %h", i, cons_pc[i], 32'(i*4+4)); end
            end
        end
    endtask

    task automatic test_branch_outstanding();
        int n;
        do_reset();
        mem_lat = 3;
        imem_req_ready = 1'b1;
        n = 0;
        while (req_log.size() < 3 && n < 40) begin tick(); n++; end
        total++; if (req_log.size() != 3) begin bad++; $display("FAIL br_wait_req: got %0d want 3 (timeout)", req_log.size()); end
        total++; if (imem_addr !== 32'hC) begin bad++; $display("FAIL br_fetch_pc: got %h want c", imem_addr); end
        cons_pc.delete();
        cons_data.delete();
        branch_taken = 1'b1;
        branch_addr  = 32'h100;
        #1;
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL br_no_req: got %b want 0", imem_req_valid); end
        tick();
        branch_taken = 1'b0;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL br_flush: got %b want 0", instr_valid); end
        repeat (20) tick();
        total++;
        if (req_log.size() < 4 || cons_pc.size() < 1) begin
            bad++; $display("FAIL br_after_len: got req=%0d cons=%0d want >=4,>=1", req_log.size(), cons_pc.size());
        end else begin
            total++; if (req_log[3] !== 32'h100) begin bad++; $display("FAIL br_next_req: got %h want 100", req_log[3]); end
            total++; if (cons_pc[0] !== 32'h104) begin bad++; $display("FAIL br_next_pc: got %h want 104", cons_pc[0]); end
            total++; if (cons_data[0] !== 32'hDEAD_0100) begin bad++; $display("FAIL br_next_data: got %h want dead0100", cons_data[0]); end
        end
    endtask

    task automatic test_branch_with_rsp();
        int n;
        do_reset();
        mem_lat = 1;
        imem_req_ready = 1'b1;
        n = 0;
        while (!imem_rsp_valid && n < 20) begin tick(); n++; end
        total++; if (imem_rsp_valid !== 1'b1) begin bad++; $display("FAIL brr_wait_rsp: got %b want 1 (timeout)", imem_rsp_valid); end
        branch_taken = 1'b1;
        branch_addr  = 32'h200;
        tick();
        branch_taken = 1'b0;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL brr_discard: got %b want 0", instr_valid); end
        repeat (15) tick();
        total++;
        if (req_log.size() < 2 || cons_pc.size() < 1) begin
            bad++; $display("FAIL brr_len: got req=%0d cons=%0d want >=2,>=1", req_log.size(), cons_pc.size());
        end else begin
            total++; if (req_log[1] !== 32'h200) begin bad++; $display("FAIL brr_next_req: got %h want 200", req_log[1]); end
            total++; if (cons_pc[0] !== 32'h204) begin bad++; $display("FAIL brr_next_pc: got %h want 204", cons_pc[0]); end
            total++; if (cons_data[0] !== 32'hDEAD_0200) begin bad++; $display("FAIL brr_next_data: got %h want dead0200", cons_data[0]); end
        end
    endtask

    task automatic test_ready_stall();
        do_reset();
        mem_lat = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL stall_valid%0d: got %b want 1", i, imem_req_valid); end
            total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL stall_addr%0d: got %h want 0", i, imem_addr); end
        end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        total++; if (req_log.size() != 1) begin bad++; $display("FAIL stall_accept_cnt: got %0d want 1", req_log.size()); end
        total++; if (imem_addr !== 32'h4) begin bad++; $display("FAIL stall_advance: got %h want 4", imem_addr); end
    endtask

    task automatic test_reset_midreq();
        int n;
        do_reset();
        mem_lat = 4;
        imem_req_ready = 1'b1;
        n = 0;
        while (req_log.size() < 2 && n < 40) begin tick(); n++; end
        total++; if (req_log.size() != 2) begin bad++; $display("FAIL rmid_wait: got %0d want 2 (timeout)", req_log.size()); end
        rst = 1'b0;
        tick();
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rmid_req_valid: got %b want 0", imem_req_valid); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rmid_instr_valid: got %b want 0", instr_valid); end
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL rmid_pc: got %h want 0", pc); end
        total++; if (instruction !== 32'h0) begin bad++; $display("FAIL rmid_instr: got %h want 0", instruction); end
        rst = 1'b1;
        clear_logs();
        repeat (30) tick();
        total++;
        if (req_log.size() < 1 || cons_pc.size() < 2) begin
            bad++; $display("FAIL rmid_len: got req=%0d cons=%0d want >=1,>=2", req_log.size(), cons_pc.size());
        end else begin
            total++; if (req_log[0] !== 32'h0) begin bad++; $display("FAIL rmid_first_req: got %h want 0", req_log[0]); end
            total++; if (cons_pc[0] !== 32'h4) begin bad++; $display("FAIL rmid_pc0: got %h want 4", cons_pc[0]); end
            total++; if (cons_data[0] !== 32'hDEAD_0000) begin bad++; $display("FAIL rmid_data0: got %h want dead0000", cons_data[0]); end
            total++; if (cons_pc[1] !== 32'h8) begin bad++; $display("FAIL rmid_pc1: got %h want 8", cons_pc[1]); end
            total++; if (cons_data[1] !== 32'hDEAD_0004) begin bad++; $display("FAIL rmid_data1: got %h want dead0004", cons_data[1]); end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_hazard();
        test_branch_outstanding();
        test_branch_with_rsp();
        test_ready_stall();
        test_reset_midreq();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
